stream_fifo_reader: RTL and testbench

Read side of the crossbar's per-port FIFO. It pops words from a FIFO read interface with one-cycle read latency and presents them as a valid/ready stream master. A two-entry output buffer with in-flight read tracking sustains one beat per clock under continuous ready and stalls without loss or duplication. It sits between each ingress FIFO and the crossbar arbitration stage.

---
 rtl/stream_xbar_pkg.sv | 14 +
 rtl/stream_fifo_reader_if.sv | 12 +
 rtl/stream_out_buf.sv | 54 +++++
 rtl/stream_fifo_reader.sv | 87 ++++++++
 tb/tb_stream_fifo_reader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_xbar_pkg.sv
// Shared types and constants for the crossbar stream read path.
package stream_xbar_pkg;

  localparam int BUF_DEPTH       = 2;
  localparam int BEAT_DATA_WIDTH = 8;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic [BEAT_DATA_WIDTH-1:0] data;
    logic                       last;
  } stream_beat_t;

endpackage

// File: rtl/stream_fifo_reader_if.sv
// Valid/ready stream bundle between a FIFO reader and the crossbar arbiter.
interface stream_fifo_reader_if #(
  parameter int T_DATA_WIDTH = 8
);
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic                    m_last_o;

  modport master (output m_data_o, output m_valid_o, output m_last_o, input m_ready_i);
  modport slave  (input m_data_o, input m_valid_o, input m_last_o, output m_ready_i);
endinterface

// File: rtl/stream_out_buf.sv
// Two-entry output buffer: slot 0 is the stream head, arrivals append behind
// whatever survives this cycle's pop.
module stream_out_buf
  import stream_xbar_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [T_DATA_WIDTH-1:0] wr_data,
  input  logic                    pop,
  output occ_t                    occ,
  output logic [T_DATA_WIDTH-1:0] head
);

  occ_t                    occ_q, occ_d;
  occ_t                    occ_after_pop;
  logic [T_DATA_WIDTH-1:0] slot_q [BUF_DEPTH];
  logic [T_DATA_WIDTH-1:0] slot_d [BUF_DEPTH];

  always_comb begin
    occ_after_pop = occ_q - {1'b0, pop};
    slot_d        = slot_q;
    if (pop && occ_q == 2'd2) begin
      slot_d[0] = slot_q[1];
    end
    // A write can only happen when at most one word survives the pop.
    if (wr_en) begin
      slot_d[occ_after_pop[0]] = wr_data;
    end
    occ_d = occ_after_pop + {1'b0, wr_en};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        slot_q[gi] <= slot_d[gi];
      end
    end
  endgenerate

  assign occ  = occ_q;
  assign head = slot_q[0];

endmodule

// File: rtl/stream_fifo_reader.sv
// FIFO read side to valid/ready stream master with one-cycle read latency.
// Optional packet-last generation enabled by defining STREAM_RD_LAST_EN.
module stream_fifo_reader
  import stream_xbar_pkg::*;
#(
  parameter int T_DATA_WIDTH  = 8,
  parameter int PKT_LEN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [T_DATA_WIDTH-1:0]  fifo_data,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  stream_fifo_reader_if.master     m,
  input  logic [PKT_LEN_WIDTH-1:0] pkt_len_i,
  output logic [1:0]               level_o
);

  logic                    inflight_q, inflight_d;
  occ_t                    occ;
  logic [T_DATA_WIDTH-1:0] head;
  logic                    valid;
  logic                    pop;
  logic [2:0]              committed;
  logic                    last;

  stream_out_buf #(
    .T_DATA_WIDTH (T_DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight_q),
    .wr_data (fifo_data),
    .pop     (pop),
    .occ     (occ),
    .head    (head)
  );

  assign valid = (occ != 2'd0);
  assign pop   = valid && m.m_ready_i;

  // Words already owned (buffered or in flight) after this cycle's pop must leave
  // room for the read we are about to issue.
  always_comb begin
    committed  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = rst_n && !fifo_empty && (committed < 3'd2);
    inflight_d = fifo_rd_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

`ifdef STREAM_RD_LAST_EN
  logic [PKT_LEN_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    last  = valid && (cnt_q == pkt_len_i);
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_pkt_len;
  assign unused_pkt_len = ^pkt_len_i;
  assign last           = 1'b0;
`endif

  assign m.m_data_o  = head;
  assign m.m_valid_o = valid;
  assign m.m_last_o  = last;
  assign level_o     = occ;

endmodule

// File: tb/tb_stream_fifo_reader.sv
// Bench for stream_fifo_reader: queue-based reference model plus directed scenarios.
module tb_stream_fifo_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] pkt_len;
  logic [1:0] level;

  stream_fifo_reader_if #(.T_DATA_WIDTH(8)) m_if ();

  stream_fifo_reader #(
    .T_DATA_WIDTH  (8),
    .PKT_LEN_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m          (m_if),
    .pkt_len_i  (pkt_len),
    .level_o    (level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] tb_fifo [$];
  logic [7:0] mdl_buf [$];
  bit         mdl_inflight = 0;
  logic [7:0] mdl_word = '0;
  int         mdl_cnt = 0;

  bit         obs_valid, obs_rd, obs_last;
  logic [7:0] obs_data;
  int         obs_level;
  int         got_data [$];
  int         got_last [$];
  int         got_cyc  [$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_log();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) tb_fifo.push_back(8'(first + i));
  endtask

  // One clock: drive inputs, sample, compare with the model, advance the model.
  task automatic step(input bit rst_v, input bit rdy_v, input logic [7:0] pkt_v);
    bit exp_valid, exp_rd, exp_last, pop_e;
    int exp_level;
    @(negedge clk);
    rst_n          = rst_v;
    m_if.m_ready_i = rdy_v;
    pkt_len        = pkt_v;
    fifo_empty     = (tb_fifo.size() == 0);
    fifo_data      = mdl_inflight ? mdl_word : 8'($urandom);
    #1;
    obs_valid = m_if.m_valid_o;
    obs_data  = m_if.m_data_o;
    obs_last  = m_if.m_last_o;
    obs_rd    = fifo_rd_en;
    obs_level = int'(level);

    exp_valid = (mdl_buf.size() != 0);
    exp_level = mdl_buf.size();
    pop_e     = exp_valid && rdy_v;
    exp_rd    = rst_v && !fifo_empty &&
                (exp_level + int'(mdl_inflight) - int'(pop_e) < 2);
`ifdef STREAM_RD_LAST_EN
    exp_last  = exp_valid && (mdl_cnt == int'(pkt_v));
`else
    exp_last  = 1'b0;
`endif
    check("valid", int'(obs_valid), int'(exp_valid));
    check("level", obs_level, exp_level);
    check("rd_en", int'(obs_rd), int'(exp_rd));
    check("last", int'(obs_last), int'(exp_last));
    if (exp_valid) check("data", int'(obs_data), int'(mdl_buf[0]));

    if (obs_valid && rdy_v && rst_v) begin
      got_data.push_back(int'(obs_data));
      got_last.push_back(int'(obs_last));
      got_cyc.push_back(cyc);
    end

    if (!rst_v) begin
      mdl_buf.delete();
      mdl_inflight = 0;
      mdl_cnt      = 0;
    end else begin
      if (pop_e) begin
        mdl_cnt = exp_last ? 0 : mdl_cnt + 1;
        void'(mdl_buf.pop_front());
      end
      if (mdl_inflight) mdl_buf.push_back(mdl_word);
      mdl_inflight = 0;
      if (obs_rd && tb_fifo.size() > 0) begin
        mdl_inflight = 1;
        mdl_word     = tb_fifo.pop_front();
      end
    end
    cyc++;
  endtask

  initial begin
    int first_rd, first_valid, nrd;
    rst_n          = 1'b0;
    m_if.m_ready_i = 1'b0;
    fifo_empty     = 1'b1;
    fifo_data      = '0;
    pkt_len        = 8'd3;

    // Reset held with a non-empty FIFO: nothing may be read or presented.
    load(8'h10, 8);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 8'd3);
      check("rst_rd", int'(obs_rd), 0);
      check("rst_valid", int'(obs_valid), 0);
      check("rst_level", obs_level, 0);
    end

    // Streaming at full rate.
    clear_log();
    first_rd = -1;
    first_valid = -1;
    for (int i = 0; i < 14; i++) begin
      step(1, 1, 8'd3);
      if (obs_rd && first_rd < 0) first_rd = cyc - 1;
      if (obs_valid && first_valid < 0) first_valid = cyc - 1;
    end
    check("stream_latency", first_valid - first_rd, 2);
    check("stream_count", got_data.size(), 8);
    for (int k = 0; k < 8 && k < got_data.size(); k++) check("stream_data", got_data[k], 8'h10 + k);
    if (got_cyc.size() == 8) check("stream_gap", got_cyc[7] - got_cyc[0], 7);

    // Backpressure: only two words may be pulled in.
    step(0, 0, 8'd3);
    load(8'h10, 5);
    nrd = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 8'd3);
      nrd += int'(obs_rd);
    end
    check("bp_reads", nrd, 2);
    check("bp_level", obs_level, 2);
    check("bp_head", int'(obs_data), 8'h10);
    clear_log();
    for (int i = 0; i < 10; i++) step(1, 1, 8'd3);
    check("bp_count", got_data.size(), 5);
    for (int k = 0; k < 5 && k < got_data.size(); k++) check("bp_data", got_data[k], 8'h10 + k);
    if (got_cyc.size() == 5) check("bp_gap", got_cyc[4] - got_cyc[0], 4);

    // Underflow then refill.
    step(0, 0, 8'd3);
    load(8'h20, 3);
    clear_log();
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 8'd3);
      if (fifo_empty) check("uf_rd_when_empty", int'(obs_rd), 0);
    end
    check("uf_count", got_data.size(), 3);
    check("uf_valid_drop", int'(obs_valid), 0);
    load(8'h23, 4);
    clear_log();
    for (int i = 0; i < 8; i++) step(1, 1, 8'd3);
    check("refill_count", got_data.size(), 4);
    for (int k = 0; k < 4 && k < got_data.size(); k++) check("refill_data", got_data[k], 8'h23 + k);

`ifdef STREAM_RD_LAST_EN
    // Packet boundaries with pkt_len 3 under random stalls.
    step(0, 0, 8'd3);
    load(8'h50, 8);
    clear_log();
    for (int i = 0; i < 80 && got_data.size() < 8; i++) step(1, 1'($urandom_range(0, 1)), 8'd3);
    check("last_count", got_data.size(), 8);
    for (int k = 0; k < got_last.size(); k++) check("last_flag", got_last[k], (k % 4 == 3) ? 1 : 0);
`endif

    // Reset while one word is buffered and one is in flight.
    step(0, 0, 8'd3);
    load(8'h30, 5);
    step(1, 0, 8'd3);
    step(1, 0, 8'd3);
    check("mid_level_pre", obs_level, 0);
    step(0, 0, 8'd3);
    step(0, 0, 8'd3);
    check("mid_valid", int'(obs_valid), 0);
    check("mid_level", obs_level, 0);
    check("mid_rd", int'(obs_rd), 0);
    check("mid_last", int'(obs_last), 0);
    tb_fifo.delete();
    load(8'h40, 3);
    clear_log();
    for (int i = 0; i < 8; i++) step(1, 1, 8'd3);
    check("mid_count", got_data.size(), 3);
    for (int k = 0; k < 3 && k < got_data.size(); k++) check("mid_data", got_data[k], 8'h40 + k);

    // Random traffic against the model.
    begin
      logic [7:0] pl;
      bit r;
      pl = 8'd3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 2) == 0 && tb_fifo.size() < 20) tb_fifo.push_back(8'($urandom));
        r = ($urandom_range(0, 299) != 0);
        if (!r) pl = 8'($urandom_range(0, 5));
        step(r, ($urandom_range(0, 3) != 0), pl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
